opcode_encoder: RTL and testbench
=================================

Name: opcode_encoder

Overview:
- Reverse of the 3-to-8 opcode decoder: turns event/request lines back into a binary opcode.
- Captures pulses on 8 request lines into a pending register and selects one pending line per transaction by priority.
- Presents the winner's 3-bit index through a valid/ready handshake and clears that pending bit on acceptance.
- Sits between board-level event sources (buttons, peripheral strobes) and the downstream opcode consumer.

Parameters:
- N, 8, number of request lines; must equal 2**CODE_W.
- CODE_W, 3, opcode width in bits.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request strobes; any bit high for ≥1 cycle sets its pending bit; multiple bits may be high at once.
- code  output  CODE_W  encoded index of the granted line; stable while code_valid=1.
- code_valid  output  1  code holds a granted opcode.
- code_ready  input  1  consumer accepts code this cycle when code_valid=1.
- pending  output  N  current pending register, for debug/LEDs.
- overflow  output  1  sticky: a req bit arrived while its pending bit was already set; cleared only by rst.

Behaviour:
- Reset, while rst=1 at a clock edge: pend=0, code=0, code_valid=0, overflow=0, state=IDLE. rst overrides all other activity, including a transaction in flight; that transaction is dropped.
- Pending update each edge: pend_next = (pend & ~clr) | req.
  - clr is one-hot at the granted index only on a handshake edge (code_valid & code_ready); otherwise clr=0.
  - Set wins over clear: req on the index being cleared in the same cycle leaves the bit set.
- Overflow: set at an edge where (req & pend & ~clr) != 0.
- FSM, 2 states:
  - IDLE: code_valid=0. If pend != 0, at the next edge load code = selected index, code_valid=1, go to PRESENT. Selection uses the registered pend, not raw req.
  - PRESENT: code_valid=1; code and the grant are frozen regardless of new req. On an edge with code_ready=1, clear the granted pend bit, code_valid=0, go to IDLE. code keeps its last value while invalid.
- Priority: fixed, lowest index wins (bit 0 highest priority), unless ROUND_ROBIN_EN is defined.
- Latency and throughput:
  - req high in cycle t → pend bit set after edge t.
  - code_valid=1 from cycle t+2 (two cycles), if the FSM was IDLE.
  - Back-to-back grants have a one-cycle bubble (valid low for one cycle between transactions).
  - Maximum throughput is 1 opcode per 2 cycles.
- code_ready while code_valid=0 is ignored.
- All N lines pending: served one at a time in priority order, N transactions, then IDLE with pend=0.

Optional Feature:
- Macro: OPCODE_ENCODER_ROUND_ROBIN_EN.
- Defined:
  - Adds a CODE_W-bit pointer last, reset to N-1.
  - Selection scans pend starting at index (last+1) mod N and wraps around.
  - last updates to the granted index on each handshake.
  - Starvation-free: each pending line is served within N grants.
- Undefined: fixed lowest-index priority, no pointer register. All other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req=0 → code_valid=0, code=0, pending=0, overflow=0 for 10 cycles.
- Single request, ready tied high:
  - req=8'b0010_0000 for 1 cycle at t → code_valid=1 with code=3'd5 at t+2.
  - Handshake at t+2; pending=0 and code_valid=0 at t+3.
- Multiple requests, fixed priority:
  - req=8'b1000_0101 for 1 cycle, code_ready=1 → codes 0, 2, 7 in order, each valid for one cycle with one-cycle gaps.
  - Round-robin build: same stimulus yields 0, 2, 7 from reset pointer 7.
  - Round-robin follow-up: after that, req=8'b1000_0001 yields 0 then 7 (pointer wraps).
- Backpressure and overflow:
  - req=8'b0000_1000, code_ready=0 for 5 cycles → code=3 held with code_valid=1.
  - Second req pulse on bit 3 during that window → overflow=1.
  - Assert code_ready → one handshake; pending=0.
- Set-wins collision: on the handshake edge of code=3, drive req bit 3 again → pending[3] stays 1; code=3 presented again after the bubble.
- Reset mid-transaction: code_valid=1 with pending=8'hF0, pulse rst → next cycle code_valid=0, pending=0, overflow=0; no grant until new req.

Source files
------------

// File: rtl/opcode_encoder.sv
// Priority encoder with pulse capture: latches request strobes into a pending register and
// hands out one winner index per valid/ready transaction. Define OPCODE_ENCODER_ROUND_ROBIN_EN for rotating priority.
module opcode_encoder #(
    parameter int N      = 8,
    parameter int CODE_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    output logic [CODE_W-1:0] code,
    output logic              code_valid,
    input  logic              code_ready,
    output logic [N-1:0]      pending,
    output logic              overflow
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PRESENT = 1'b1;

    logic [0:0]        state;
    logic [N-1:0]      pend;
    logic [N-1:0]      clr;
    logic [CODE_W-1:0] sel;
    logic              handshake;

`ifdef OPCODE_ENCODER_ROUND_ROBIN_EN
    logic [CODE_W-1:0] last;
`endif

    assign handshake = code_valid & code_ready;
    assign pending   = pend;

    // The granted index is whatever code holds, since code is frozen while presenting.
    always_comb begin
        clr = '0;
        if (handshake) begin
            clr[code] = 1'b1;
        end
    end

`ifdef OPCODE_ENCODER_ROUND_ROBIN_EN
    // Scan starts one past the previous winner and wraps; N is a power of two so
    // the CODE_W-bit add wraps naturally.
    always_comb begin
        logic              found;
        logic [CODE_W-1:0] idx;
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = last + CODE_W'(i + 1);
            if (pend[idx] && !found) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        logic found;
        found = 1'b0;
        sel   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (pend[i] && !found) begin
                sel   = CODE_W'(i);
                found = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= '0;
            overflow <= 1'b0;
        end else begin
            pend <= (pend & ~clr) | req;
            if (|(req & pend & ~clr)) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            code       <= '0;
            code_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pend) begin
                        code       <= sel;
                        code_valid <= 1'b1;
                        state      <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (code_ready) begin
                        code_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    code_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

`ifdef OPCODE_ENCODER_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= CODE_W'(N - 1);
        end else if (handshake) begin
            last <= code;
        end
    end
`endif

endmodule

// File: tb/tb_opcode_encoder.sv
// Directed bench for opcode_encoder: capture, priority order, backpressure,
// overflow, set-wins collision and reset during a transaction.
module tb_opcode_encoder;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [2:0] code;
    logic       code_valid;
    logic       code_ready;
    logic [7:0] pending;
    logic       overflow;

    int total;
    int bad;

    opcode_encoder #(.N(8), .CODE_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .code       (code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .pending    (pending),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        req        = '0;
        code_ready = 1'b0;

        // reset then idle
        step();
        step();
        rst = 1'b0;
        chk("rst_valid", 32'(code_valid), 32'd0);
        chk("rst_code", 32'(code), 32'd0);
        chk("rst_pending", 32'(pending), 32'h00);
        chk("rst_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_valid", 32'(code_valid), 32'd0);
            chk("idle_pending", 32'(pending), 32'h00);
        end

        // single request, ready high
        code_ready = 1'b1;
        req = 8'h20;
        step();
        req = 8'h00;
        chk("single_pend", 32'(pending), 32'h20);
        chk("single_t1_valid", 32'(code_valid), 32'd0);
        step();
        chk("single_valid", 32'(code_valid), 32'd1);
        chk("single_code", 32'(code), 32'd5);
        step();
        chk("single_done_valid", 32'(code_valid), 32'd0);
        chk("single_done_pend", 32'(pending), 32'h00);
        chk("single_code_hold", 32'(code), 32'd5);

        // multiple requests: 0, 2, 7 with bubbles
        req = 8'h85;
        step();
        req = 8'h00;
        chk("multi_pend", 32'(pending), 32'h85);
        step();
        chk("multi_v0", 32'(code_valid), 32'd1);
        chk("multi_c0", 32'(code), 32'd0);
        step();
        chk("multi_gap0", 32'(code_valid), 32'd0);
        chk("multi_pend0", 32'(pending), 32'h84);
        step();
        chk("multi_v1", 32'(code_valid), 32'd1);
        chk("multi_c1", 32'(code), 32'd2);
        step();
        chk("multi_gap1", 32'(code_valid), 32'd0);
        chk("multi_pend1", 32'(pending), 32'h80);
        step();
        chk("multi_v2", 32'(code_valid), 32'd1);
        chk("multi_c2", 32'(code), 32'd7);
        step();
        chk("multi_gap2", 32'(code_valid), 32'd0);
        chk("multi_pend2", 32'(pending), 32'h00);

        // follow-up: 0 then 7 (pointer wraps in round-robin build)
        req = 8'h81;
        step();
        req = 8'h00;
        step();
        chk("wrap_v0", 32'(code_valid), 32'd1);
        chk("wrap_c0", 32'(code), 32'd0);
        step();
        chk("wrap_gap", 32'(code_valid), 32'd0);
        step();
        chk("wrap_v1", 32'(code_valid), 32'd1);
        chk("wrap_c1", 32'(code), 32'd7);
        step();
        chk("wrap_done_pend", 32'(pending), 32'h00);
        chk("wrap_done_valid", 32'(code_valid), 32'd0);

        // backpressure and overflow
        code_ready = 1'b0;
        req = 8'h08;
        step();
        req = 8'h00;
        step();
        chk("bp_valid", 32'(code_valid), 32'd1);
        chk("bp_code", 32'(code), 32'd3);
        chk("bp_ovf_before", 32'(overflow), 32'd0);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) req = 8'h08;
            step();
            req = 8'h00;
            chk("bp_hold_valid", 32'(code_valid), 32'd1);
            chk("bp_hold_code", 32'(code), 32'd3);
        end
        chk("bp_overflow", 32'(overflow), 32'd1);
        code_ready = 1'b1;
        step();
        chk("bp_hs_valid", 32'(code_valid), 32'd0);
        chk("bp_hs_pend", 32'(pending), 32'h00);
        chk("bp_ovf_sticky", 32'(overflow), 32'd1);
        step();
        chk("bp_no_regrant", 32'(code_valid), 32'd0);

        // set-wins collision, from a clean reset so overflow is observable
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("sw_rst_ovf", 32'(overflow), 32'd0);
        code_ready = 1'b0;
        req = 8'h08;
        step();
        req = 8'h00;
        step();
        chk("sw_valid", 32'(code_valid), 32'd1);
        chk("sw_code", 32'(code), 32'd3);
        code_ready = 1'b1;
        req = 8'h08;
        step();
        req = 8'h00;
        chk("sw_pend_kept", 32'(pending), 32'h08);
        chk("sw_bubble", 32'(code_valid), 32'd0);
        chk("sw_no_ovf", 32'(overflow), 32'd0);
        step();
        chk("sw_again_valid", 32'(code_valid), 32'd1);
        chk("sw_again_code", 32'(code), 32'd3);
        step();
        chk("sw_final_pend", 32'(pending), 32'h00);
        chk("sw_final_valid", 32'(code_valid), 32'd0);

        // reset mid-transaction
        code_ready = 1'b0;
        req = 8'hF0;
        step();
        req = 8'h00;
        step();
        chk("mr_valid", 32'(code_valid), 32'd1);
        chk("mr_code", 32'(code), 32'd4);
        chk("mr_pend", 32'(pending), 32'hF0);
        req = 8'h10;
        step();
        req = 8'h00;
        chk("mr_ovf", 32'(overflow), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_rst_valid", 32'(code_valid), 32'd0);
        chk("mr_rst_pend", 32'(pending), 32'h00);
        chk("mr_rst_ovf", 32'(overflow), 32'd0);
        chk("mr_rst_code", 32'(code), 32'd0);
        code_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mr_quiet_valid", 32'(code_valid), 32'd0);
        end
        req = 8'h02;
        step();
        req = 8'h00;
        step();
        chk("mr_new_valid", 32'(code_valid), 32'd1);
        chk("mr_new_code", 32'(code), 32'd1);
        step();
        chk("mr_new_pend", 32'(pending), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
